// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I/D main-memory arbiter.
// Line geometry, FSM state encodings and the latency-counter sizing rule.
package mem_arbiter_pkg;

    localparam int WORD_SIZE  = 16;
    localparam int LINE_WORDS = 4;
    localparam int LINE_BITS  = WORD_SIZE * LINE_WORDS;
    localparam int ADDR_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A single-cycle latency still needs a one-bit counter.
    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/mem_latency_counter.sv
// Down-counter modelling the fixed memory access time.
// Loaded on grant, decremented while busy, saturates at zero.
module mem_latency_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port
// between the instruction cache and the data cache.
module mem_arbiter #(
    parameter int WORD_SIZE  = mem_arbiter_pkg::WORD_SIZE,
    parameter int LINE_WORDS = mem_arbiter_pkg::LINE_WORDS,
    parameter int LATENCY    = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_req,
    input  logic [15:0]                      i_addr,
    output logic                             i_ack,
    output logic [WORD_SIZE*LINE_WORDS-1:0]  i_rdata,
    input  logic                             d_req,
    input  logic                             d_we,
    input  logic [15:0]                      d_addr,
    input  logic [WORD_SIZE*LINE_WORDS-1:0]  d_wdata,
    output logic                             d_ack,
    output logic [WORD_SIZE*LINE_WORDS-1:0]  d_rdata,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic [15:0]                      mem_addr,
    output logic [WORD_SIZE*LINE_WORDS-1:0]  mem_wdata,
    input  logic [WORD_SIZE*LINE_WORDS-1:0]  mem_rdata,
    output logic                             busy
);

    import mem_arbiter_pkg::*;

    localparam int LB = WORD_SIZE * LINE_WORDS;
    localparam int CW = cnt_width(LATENCY);
    localparam logic [CW-1:0] LOAD = CW'(LATENCY - 1);

    state_t          state;
    logic            owner_d;
    logic            we;
    logic            last_d;
    logic [15:0]     addr_q;
    logic [LB-1:0]   wdata_q;
    logic            zero;
    logic            grant_d;
    logic            start;
    logic            unused_addr;

    // D wins unless I is also waiting and D was served last.
    assign grant_d = d_req && (!i_req || !last_d);
    assign start   = (state == ST_IDLE) && (i_req || d_req);

    mem_latency_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (start),
        .dec      (state == ST_BUSY),
        .load_val (LOAD),
        .zero     (zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            owner_d <= 1'b0;
            we      <= 1'b0;
            last_d  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        owner_d <= grant_d;
                        we      <= grant_d && d_we;
                        addr_q  <= grant_d ? {d_addr[15:2], 2'b00}
                                           : {i_addr[15:2], 2'b00};
                        wdata_q <= grant_d ? d_wdata : '0;
                        state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (zero) begin
                        if (!we && owner_d)  d_rdata <= mem_rdata;
                        if (!we && !owner_d) i_rdata <= mem_rdata;
                        last_d <= owner_d;
                        i_ack  <= !owner_d;
                        d_ack  <= owner_d;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign mem_read  = (state == ST_BUSY) && !we;
    assign mem_write = (state == ST_BUSY) && zero && we && !reset;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign unused_addr = ^{i_addr[1:0], d_addr[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: LATENCY=4 instance with a word
// memory, plus a LATENCY=1 instance for the minimum-latency case.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        i_req = 0, d_req = 0, d_we = 0;
    logic [15:0] i_addr = 0, d_addr = 0;
    logic [63:0] d_wdata = 0;
    logic        i_ack, d_ack, mem_read, mem_write, busy;
    logic [63:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [15:0] mem_addr;

    logic        i1_req = 0;
    logic [15:0] i1_addr = 0;
    logic        i1_ack, d1_ack, mem1_read, mem1_write, busy1;
    logic [63:0] i1_rdata, d1_rdata, mem1_wdata, mem1_rdata;
    logic [15:0] mem1_addr;

    logic [15:0] mem [256];
    logic [7:0]  ma;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.LATENCY(4)) u_dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .i_req(i1_req), .i_addr(i1_addr), .i_ack(i1_ack), .i_rdata(i1_rdata),
        .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(64'h0),
        .d_ack(d1_ack), .d_rdata(d1_rdata),
        .mem_read(mem1_read), .mem_write(mem1_write), .mem_addr(mem1_addr),
        .mem_wdata(mem1_wdata), .mem_rdata(mem1_rdata), .busy(busy1)
    );

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
    end

    assign ma = mem_addr[7:0];

    always_comb begin
        mem_rdata = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
        mem1_rdata = {16'hB000 + mem1_addr + 16'd3,
                      16'hB000 + mem1_addr + 16'd2,
                      16'hB000 + mem1_addr + 16'd1,
                      16'hB000 + mem1_addr};
    end

    always @(posedge clk) begin
        if (mem_write) begin
            for (int k = 0; k < 4; k++)
                mem[ma + 8'(k)] <= mem_wdata[16*k +: 16];
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        check("rst_iack", i_ack, 0);
        check("rst_dack", d_ack, 0);
        check("rst_rd", mem_read, 0);
        check("rst_wr", mem_write, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_irdata", i_rdata, 0);
        check("rst_drdata", d_rdata, 0);
        check("rst_busy1", busy1, 0);
        reset = 1'b0;
    endtask

    task automatic i_fill(input logic [15:0] a, input logic [63:0] exp);
        i_req  = 1'b1;
        i_addr = a;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("ifill_ack", i_ack, k == 5);
        end
        check("ifill_rdata", i_rdata, exp);
        step();
        i_req = 1'b0;
    endtask

    initial begin
        do_reset();

        // I-cache fill of line 0x10
        i_req  = 1'b1;
        i_addr = 16'h0013;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k <= 4) begin
                check("if_busy", busy, 1);
                check("if_addr", mem_addr, 16'h0010);
                check("if_rd", mem_read, 1);
                check("if_ack_early", i_ack, 0);
            end else begin
                check("if_ack", i_ack, 1);
                check("if_rdata", i_rdata, 64'hA013_A012_A011_A010);
                check("if_rd_done", mem_read, 0);
            end
        end
        step();
        i_req = 1'b0;
        check("if_idle", busy, 0);
        check("if_ack_pulse", i_ack, 0);

        // Tie after reset, both requests held: D, I, D, I
        do_reset();
        i_req  = 1'b1;
        d_req  = 1'b1;
        d_we   = 1'b0;
        i_addr = 16'h0021;
        d_addr = 16'h0032;
        for (int k = 1; k <= 23; k++) begin
            step();
            check("rr_dack", d_ack, (k == 5) || (k == 17));
            check("rr_iack", i_ack, (k == 11) || (k == 23));
            if (k == 5)
                check("rr_drdata", d_rdata, 64'hA033_A032_A031_A030);
            if (k == 11)
                check("rr_irdata", i_rdata, 64'hA023_A022_A021_A020);
        end
        step();
        i_req = 1'b0;
        d_req = 1'b0;
        step();
        check("rr_idle", busy, 0);

        // D write-back of line 0x40
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0042;
        d_wdata = 64'h1111_2222_3333_4444;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("wb_wr", mem_write, k == 4);
            check("wb_rd", mem_read, 0);
            check("wb_ack", d_ack, k == 5);
            if (k == 4) check("wb_addr", mem_addr, 16'h0040);
        end
        step();
        d_req = 1'b0;
        d_we  = 1'b0;
        check("wb_mem", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]},
              64'h1111_2222_3333_4444);
        check("wb_drdata", d_rdata, 64'hA033_A032_A031_A030);
        i_fill(16'h0041, 64'h1111_2222_3333_4444);

        // Reset in cycle 2 of a write aborts it
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0050;
        d_wdata = 64'hDEAD_BEEF_CAFE_F00D;
        step();
        check("ab_busy", busy, 1);
        check("ab_wr1", mem_write, 0);
        step();
        reset = 1'b1;
        check("ab_wr2", mem_write, 0);
        step();
        reset = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
        check("ab_busy3", busy, 0);
        for (int k = 4; k <= 8; k++) begin
            step();
            check("ab_wr", mem_write, 0);
            check("ab_dack", d_ack, 0);
            check("ab_iack", i_ack, 0);
        end
        check("ab_mem", {mem[8'h53], mem[8'h52], mem[8'h51], mem[8'h50]},
              64'hA053_A052_A051_A050);
        i_fill(16'h0050, 64'hA053_A052_A051_A050);

        // LATENCY=1: ack in cycle 2, held request waits for IDLE
        i1_req  = 1'b1;
        i1_addr = 16'h0009;
        step();
        check("l1_busy1", busy1, 1);
        check("l1_rd", mem1_read, 1);
        check("l1_addr", mem1_addr, 16'h0008);
        check("l1_ack_early", i1_ack, 0);
        step();
        check("l1_ack", i1_ack, 1);
        check("l1_rdata", i1_rdata, 64'hB00B_B00A_B009_B008);
        step();
        check("l1_idle", busy1, 0);
        check("l1_ack_pulse", i1_ack, 0);
        step();
        check("l1_regrant", busy1, 1);
        step();
        check("l1_ack2", i1_ack, 1);
        step();
        i1_req = 1'b0;
        check("l1_idle2", busy1, 0);
        step();
        check("l1_stay", busy1, 0);
        check("l1_dack", d1_ack, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
